// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker: polynomial modes, their
// length/tap constants, the checker state encoding and mask helpers.
package prbs_pkg;

  localparam int LFSR_W = 31;

  typedef enum logic [2:0] {
    PRBS7  = 3'd0,
    PRBS9  = 3'd1,
    PRBS15 = 3'd2,
    PRBS23 = 3'd3,
    PRBS31 = 3'd4
  } prbs_mode_e;

  // Polynomial x^LEN + x^TAP + 1 for each mode
  localparam int PRBS7_LEN  = 7;
  localparam int PRBS7_TAP  = 6;
  localparam int PRBS9_LEN  = 9;
  localparam int PRBS9_TAP  = 5;
  localparam int PRBS15_LEN = 15;
  localparam int PRBS15_TAP = 14;
  localparam int PRBS23_LEN = 23;
  localparam int PRBS23_TAP = 18;
  localparam int PRBS31_LEN = 31;
  localparam int PRBS31_TAP = 28;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_SYNC,
    ST_LOCKED
  } chk_state_e;

  // Raw 3-bit selector to mode; unused codes fall back to PRBS31
  function automatic prbs_mode_e prbs_mode_decode(input logic [2:0] raw);
    case (raw)
      3'd0:    return PRBS7;
      3'd1:    return PRBS9;
      3'd2:    return PRBS15;
      3'd3:    return PRBS23;
      default: return PRBS31;
    endcase
  endfunction

  function automatic int prbs_len(input prbs_mode_e mode);
    case (mode)
      PRBS7:   return PRBS7_LEN;
      PRBS9:   return PRBS9_LEN;
      PRBS15:  return PRBS15_LEN;
      PRBS23:  return PRBS23_LEN;
      default: return PRBS31_LEN;
    endcase
  endfunction

  // Low 'len' bits set; keeps the unused upper LFSR bits at zero
  function automatic logic [LFSR_W-1:0] prbs_mask(input int len);
    logic [LFSR_W-1:0] m;
    m = '1;
    m = ~(m << len);
    return m;
  endfunction

endpackage

// File: rtl/prbs_par_step.sv
// Combinational DATW-bit parallel PRBS step. The state holds the most
// recent stream bits with bit 0 the newest; the first generated bit
// lands in exp_o[DATW-1].
module prbs_par_step
  import prbs_pkg::*;
#(
  parameter int DATW = 64
) (
  input  logic [LFSR_W-1:0] state_i,
  input  prbs_mode_e        mode_i,
  output logic [DATW-1:0]   exp_o,
  output logic [LFSR_W-1:0] nxt_o
);

  localparam int RW = DATW + LFSR_W;

  function automatic logic [RW-1:0] run_steps(input logic [LFSR_W-1:0] seed,
                                              input int len, input int tap);
    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] taps;
    logic [DATW-1:0]   e;
    logic              b;
    s    = seed;
    e    = '0;
    taps = (LFSR_W'(1) << (len - 1)) | (LFSR_W'(1) << (tap - 1));
    for (int i = 0; i < DATW; i++) begin
      b = ^(s & taps);
      e = {e[DATW-2:0], b};
      s = {s[LFSR_W-2:0], b};
    end
    return {e, s & prbs_mask(len)};
  endfunction

  logic [RW-1:0] r7, r9, r15, r23, r31;

  assign r7  = run_steps(state_i, PRBS7_LEN,  PRBS7_TAP);
  assign r9  = run_steps(state_i, PRBS9_LEN,  PRBS9_TAP);
  assign r15 = run_steps(state_i, PRBS15_LEN, PRBS15_TAP);
  assign r23 = run_steps(state_i, PRBS23_LEN, PRBS23_TAP);
  assign r31 = run_steps(state_i, PRBS31_LEN, PRBS31_TAP);

  // Select the unrolled variant for the active polynomial
  always_comb begin
    case (mode_i)
      PRBS7:   {exp_o, nxt_o} = r7;
      PRBS9:   {exp_o, nxt_o} = r9;
      PRBS15:  {exp_o, nxt_o} = r15;
      PRBS23:  {exp_o, nxt_o} = r23;
      default: {exp_o, nxt_o} = r31;
    endcase
  end

endmodule

// File: rtl/prbs_chk.sv
// Self-synchronising parallel PRBS checker with lock tracking and a
// saturating bit-error counter that only runs while locked.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int DATW       = 64,
  parameter int ERRW       = 32,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                imode,
  input  logic                      iinv,
  input  logic                      ivld,
  input  logic [DATW-1:0]           idat,
  input  logic                      iclr,
  output logic                      olock,
  output logic                      oerr_vld,
  output logic [$clog2(DATW+1)-1:0] oerr_bits,
  output logic [ERRW-1:0]           oerr_cnt
);

  localparam int BW = $clog2(DATW + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam int SW = ((ERRW > BW) ? ERRW : BW) + 1;
  localparam logic [SW-1:0] SAT_LIM = {{(SW-ERRW){1'b0}}, {ERRW{1'b1}}};

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [GW-1:0]     good_q, good_d;
  logic [UW-1:0]     bad_q, bad_d;
  logic [2:0]        mode_q, mode_d;
  logic              inv_q, inv_d;
  logic              vld_q, vld_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [ERRW-1:0]   cnt_q, cnt_d;

  prbs_mode_e        mode_e;
  logic [DATW-1:0]   pred_word;
  logic [LFSR_W-1:0] pred_next;
  logic [LFSR_W-1:0] seed_val;
  logic [DATW-1:0]   diff;
  logic [DATW-1:0]   pop_src;
  logic [BW-1:0]     ones;
  logic              word_err;
  logic              changed;
  logic              count_word;
  logic [SW-1:0]     ones_ext;
  logic [SW-1:0]     sum_ext;

  function automatic logic [ERRW-1:0] sat_cnt(input logic [SW-1:0] v);
    return (v > SAT_LIM) ? '1 : v[ERRW-1:0];
  endfunction

  assign mode_e   = prbs_mode_decode(imode);
  assign seed_val = (idat[LFSR_W-1:0] ^ {LFSR_W{iinv}}) & prbs_mask(prbs_len(mode_e));
  assign diff     = idat ^ pred_word ^ {DATW{iinv}};
  assign word_err = |diff;

  prbs_par_step #(.DATW(DATW)) u_step (
    .state_i (lfsr_q),
    .mode_i  (mode_e),
    .exp_o   (pred_word),
    .nxt_o   (pred_next)
  );

  // Count mismatching bits in the current word
  always_comb begin
    pop_src = diff;
    ones    = '0;
    for (int i = 0; i < DATW; i++) begin
      ones    = ones + BW'(pop_src[0]);
      pop_src = pop_src >> 1;
    end
  end

  // Seed/sync/lock sequencing and the per-word error report
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    good_d     = good_q;
    bad_d      = bad_q;
    bits_d     = '0;
    count_word = 1'b0;
    changed    = ((imode != mode_q) || (iinv != inv_q)) && (state_q != ST_SEED);
    if (changed) begin
      state_d = ST_SEED;
    end else if (ivld) begin
      case (state_q)
        ST_SEED: begin
          lfsr_d  = seed_val;
          good_d  = '0;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          bits_d = ones;
          lfsr_d = pred_next;
          if (word_err) begin
            state_d = ST_SEED;
          end else begin
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == GW'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end
          end
        end
        default: begin
          bits_d     = ones;
          lfsr_d     = pred_next;
          count_word = 1'b1;
          if (word_err) begin
            bad_d = bad_q + UW'(1);
            if (bad_q + UW'(1) == UW'(UNLOCK_CNT)) begin
              state_d = ST_SEED;
            end
          end else begin
            bad_d = '0;
          end
        end
      endcase
    end
  end

  // Saturating error total with synchronous clear
  always_comb begin
    ones_ext = SW'(ones);
    sum_ext  = SW'(cnt_q) + ones_ext;
    cnt_d    = cnt_q;
    if (iclr) begin
      cnt_d = count_word ? sat_cnt(ones_ext) : '0;
    end else if (count_word) begin
      cnt_d = sat_cnt(sum_ext);
    end
    mode_d = imode;
    inv_d  = iinv;
    vld_d  = ivld;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SEED;
      lfsr_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      mode_q  <= '0;
      inv_q   <= 1'b0;
      vld_q   <= 1'b0;
      bits_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
      vld_q   <= vld_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  end

  assign olock     = (state_q == ST_LOCKED);
  assign oerr_vld  = vld_q;
  assign oerr_bits = bits_q;
  assign oerr_cnt  = cnt_q;

endmodule

// File: tb/tb_prbs_chk.sv
// Randomised bench for prbs_chk: a queue-based stream generator drives
// the checker and a bit-serial reference model predicts every output.
module tb_prbs_chk;

  localparam int DATW       = 64;
  localparam int BW         = 7;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 4;
  localparam longint MAX32  = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4   = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      imode;
  logic            iinv, ivld, iclr;
  logic [DATW-1:0] idat;
  logic            olock, oerr_vld, olock_s, oerr_vld_s;
  logic [BW-1:0]   oerr_bits, oerr_bits_s;
  logic [31:0]     oerr_cnt;
  logic [3:0]      oerr_cnt_s;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int     m_state;
  bit     m_q[$];
  int     m_good, m_bad;
  longint m_cnt, m_cnt_s;
  logic [2:0] m_pmode;
  bit     m_pinv;
  bit     m_exp_lock, m_exp_vld;
  int     m_exp_bits;

  // Generator state
  bit     g_q[$];
  int     g_mode;
  bit     g_inv;

  always #5 clk = ~clk;

  prbs_chk #(.DATW(DATW), .ERRW(32), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .clk(clk), .rst(rst), .imode(imode), .iinv(iinv), .ivld(ivld), .idat(idat), .iclr(iclr),
    .olock(olock), .oerr_vld(oerr_vld), .oerr_bits(oerr_bits), .oerr_cnt(oerr_cnt)
  );

  prbs_chk #(.DATW(DATW), .ERRW(4), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut_s (
    .clk(clk), .rst(rst), .imode(imode), .iinv(iinv), .ivld(ivld), .idat(idat), .iclr(iclr),
    .olock(olock_s), .oerr_vld(oerr_vld_s), .oerr_bits(oerr_bits_s), .oerr_cnt(oerr_cnt_s)
  );

  function automatic int modeLen(input int md);
    case (md)
      0: return 7;
      1: return 9;
      2: return 15;
      3: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int modeTap(input int md);
    case (md)
      0: return 6;
      1: return 5;
      2: return 14;
      3: return 18;
      default: return 28;
    endcase
  endfunction

  function automatic longint satMin(input longint a, input longint lim);
    return (a > lim) ? lim : a;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0; m_q.delete(); m_good = 0; m_bad = 0;
    m_cnt = 0; m_cnt_s = 0; m_pmode = 3'd0; m_pinv = 1'b0;
    m_exp_lock = 1'b0; m_exp_vld = 1'b0; m_exp_bits = 0;
  endtask

  // Stream recurrence b[t] = b[t-N] ^ b[t-M], states 0=seed 1=sync 2=locked
  task automatic modelCycle(input bit vld, input logic [63:0] dat, input logic [2:0] md,
                            input bit inv, input bit clr);
    int n, t, bits;
    bit changed, counting, b;
    logic [63:0] d, expw;
    n = modeLen(int'(md)); t = modeTap(int'(md));
    changed = ((md != m_pmode) || (inv != m_pinv)) && (m_state != 0);
    bits = 0; counting = 1'b0; expw = '0;
    if (changed) begin
      m_state = 0;
    end else if (vld) begin
      if (m_state == 0) begin
        m_q.delete();
        d = (dat ^ {64{inv}}) << (64 - n);
        for (int k = 0; k < n; k++) begin
          m_q.push_back(d[63]);
          d = d << 1;
        end
        m_good = 0; m_state = 1;
      end else begin
        for (int k = 0; k < DATW; k++) begin
          b = m_q[m_q.size()-n] ^ m_q[m_q.size()-t];
          expw = {expw[62:0], b ^ inv};
          m_q.push_back(b);
          if (m_q.size() > 31) void'(m_q.pop_front());
        end
        bits = $countones(dat ^ expw);
        if (m_state == 1) begin
          if (bits != 0) m_state = 0;
          else begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_state = 2; m_bad = 0; end
          end
        end else begin
          counting = 1'b1;
          if (bits != 0) begin
            m_bad++;
            if (m_bad == UNLOCK_CNT) m_state = 0;
          end else m_bad = 0;
        end
      end
    end
    if (clr) begin
      m_cnt   = counting ? satMin(bits, MAX32) : 0;
      m_cnt_s = counting ? satMin(bits, MAX4) : 0;
    end else if (counting) begin
      m_cnt   = satMin(m_cnt + bits, MAX32);
      m_cnt_s = satMin(m_cnt_s + bits, MAX4);
    end
    m_exp_lock = (m_state == 2); m_exp_vld = vld; m_exp_bits = bits;
    m_pmode = md; m_pinv = inv;
  endtask

  task automatic genSeed(input int md, input bit inv, input logic [30:0] seed);
    logic [30:0] s;
    g_q.delete(); g_mode = md; g_inv = inv; s = seed;
    for (int k = 0; k < modeLen(md); k++) begin
      g_q.push_back(s[0]);
      s = s >> 1;
    end
  endtask

  task automatic genWord(output logic [63:0] w);
    int n, t;
    bit b;
    n = modeLen(g_mode); t = modeTap(g_mode); w = '0;
    for (int k = 0; k < DATW; k++) begin
      b = g_q[g_q.size()-n] ^ g_q[g_q.size()-t];
      w = {w[62:0], b ^ g_inv};
      g_q.push_back(b);
      if (g_q.size() > 31) void'(g_q.pop_front());
    end
  endtask

  // Drive one cycle, then compare both instances with the model
  task automatic applyStimulus(input string ph, input bit vld, input logic [63:0] dat, input bit clr);
    ivld = vld; idat = dat; iclr = clr;
    @(posedge clk);
    #1;
    modelCycle(vld, dat, imode, iinv, clr);
    checkOutput({ph, ".olock"}, 64'(olock), 64'(m_exp_lock));
    checkOutput({ph, ".vld"}, 64'(oerr_vld), 64'(m_exp_vld));
    checkOutput({ph, ".bits"}, 64'(oerr_bits), 64'(m_exp_bits));
    checkOutput({ph, ".cnt"}, 64'(oerr_cnt), 64'(m_cnt));
    checkOutput({ph, ".cnt_s"}, 64'(oerr_cnt_s), 64'(m_cnt_s));
    checkOutput({ph, ".olock_s"}, 64'(olock_s), 64'(m_exp_lock));
  endtask

  task automatic cleanWord(input string ph);
    logic [63:0] w;
    genWord(w);
    applyStimulus(ph, 1'b1, w, 1'b0);
  endtask

  task automatic checkAllZero(input string ph);
    checkOutput({ph, ".olock"}, 64'(olock), 0);
    checkOutput({ph, ".vld"}, 64'(oerr_vld), 0);
    checkOutput({ph, ".bits"}, 64'(oerr_bits), 0);
    checkOutput({ph, ".cnt"}, 64'(oerr_cnt), 0);
    checkOutput({ph, ".cnt_s"}, 64'(oerr_cnt_s), 0);
    checkOutput({ph, ".olock_s"}, 64'(olock_s), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] w;
    int p0, p1, p2, nvalid, lock_at;

    rst = 1'b1; imode = 3'd0; iinv = 1'b0; ivld = 1'b0; idat = '0; iclr = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    // Clean PRBS9 from all-ones seed
    imode = 3'd1; iinv = 1'b0;
    genSeed(1, 1'b0, 31'h7FFF_FFFF);
    for (int i = 1; i <= 1000; i++) begin
      cleanWord("prbs9");
      if (i == 8) checkOutput("prbs9.lock_before_9", 64'(olock), 0);
      if (i == 9) checkOutput("prbs9.lock_at_9", 64'(olock), 1);
    end
    checkOutput("prbs9.cnt_zero", 64'(oerr_cnt), 0);

    // Single flipped bit while locked
    genWord(w);
    applyStimulus("single", 1'b1, w ^ 64'h20, 1'b0);
    checkOutput("single.bits_one", 64'(oerr_bits), 1);
    checkOutput("single.cnt_one", 64'(oerr_cnt), 1);
    checkOutput("single.still_locked", 64'(olock), 1);

    // Four words with three flipped bits each drop lock
    genWord(w);
    applyStimulus("unlock_clr", 1'b1, w, 1'b1);
    for (int j = 0; j < 4; j++) begin
      genWord(w);
      p0 = int'($urandom_range(63, 0));
      p1 = (p0 + 1 + int'($urandom_range(19, 0))) % 64;
      p2 = (p1 + 1 + int'($urandom_range(19, 0))) % 64;
      w = w ^ (64'd1 << p0) ^ (64'd1 << p1) ^ (64'd1 << p2);
      applyStimulus("unlock", 1'b1, w, 1'b0);
      if (j == 2) checkOutput("unlock.held_after_3", 64'(olock), 1);
    end
    checkOutput("unlock.dropped", 64'(olock), 0);
    checkOutput("unlock.cnt_12", 64'(oerr_cnt), 12);
    for (int i = 1; i <= 9; i++) begin
      cleanWord("relock");
      if (i == 8) checkOutput("relock.before_9", 64'(olock), 0);
      if (i == 9) checkOutput("relock.at_9", 64'(olock), 1);
    end

    // Saturation of the 4-bit counter, errors interleaved with clean words
    genWord(w);
    applyStimulus("sat_clr", 1'b1, w, 1'b1);
    for (int e = 0; e < 20; e++) begin
      genWord(w);
      applyStimulus("sat", 1'b1, w ^ (64'd1 << $urandom_range(63, 0)), 1'b0);
      cleanWord("sat");
    end
    checkOutput("sat.cnt_s_15", 64'(oerr_cnt_s), 15);
    checkOutput("sat.cnt_20", 64'(oerr_cnt), 20);
    genWord(w);
    p0 = int'($urandom_range(31, 0));
    applyStimulus("sat_clr2", 1'b1, w ^ (64'd1 << p0) ^ (64'd1 << (p0 + 32)), 1'b1);
    checkOutput("sat.clr_cnt_s_2", 64'(oerr_cnt_s), 2);
    checkOutput("sat.clr_cnt_2", 64'(oerr_cnt), 2);

    // Inverted PRBS31 with sparse valid
    imode = 3'd4; iinv = 1'b1;
    applyStimulus("sparse_switch", 1'b0, 64'(0), 1'b0);
    checkOutput("sparse.switch_drops", 64'(olock), 0);
    genSeed(4, 1'b1, 31'($urandom) | 31'd1);
    nvalid = 0; lock_at = -1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        cleanWord("sparse");
        nvalid++;
      end else begin
        applyStimulus("sparse", 1'b0, {$urandom, $urandom}, 1'b0);
      end
      if (olock && lock_at < 0) lock_at = nvalid;
    end
    checkOutput("sparse.lock_after_9", 64'(lock_at), 9);
    checkOutput("sparse.cnt_held", 64'(oerr_cnt), 2);
    imode = 3'd2;
    applyStimulus("mode_switch", 1'b0, 64'(0), 1'b0);
    checkOutput("mode_switch.drops", 64'(olock), 0);

    // Reset while locked on inverted PRBS15
    genSeed(2, 1'b1, 31'($urandom) | 31'd1);
    for (int i = 0; i < 20; i++) cleanWord("pre_reset");
    checkOutput("pre_reset.locked", 64'(olock), 1);
    #3 rst = 1'b1;
    #1;
    checkAllZero("reset_mid");
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cleanWord("post_reset");
      if (i == 9) checkOutput("post_reset.lock_at_9", 64'(olock), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
